// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
// Holds the FSM state encoding, the register-index width and the mult/div timeout default.
package hazard_pkg;

    localparam int REG_W               = 5;
    localparam int MULDIV_TIMEOUT_DFLT = 32;

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The clear input wins over the increment input.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use bubbles, branch flushes and mult/div stalls.
// Controls are Mealy outputs of the registered RUN/MULDIV_WAIT state.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_TIMEOUT = MULDIV_TIMEOUT_DFLT,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] rt_EX,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             UsesRt_ID,
    input  logic             MulDiv_ID,
    input  logic             MulDiv_done,
    input  logic             BranchTaken_EX,
    input  logic             Counter_clr,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MulDiv_start,
    output logic             MulDiv_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MULDIV_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TMO = WC_W'(MULDIV_TIMEOUT);

    hcu_state_e      state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            err_q, err_d;
    logic            lu;

    assign lu = MemRead_EX && (rt_EX != '0) &&
                ((rt_EX == rs_ID) || (UsesRt_ID && (rt_EX == rt_ID)));

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MulDiv_start = 1'b0;
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        err_d        = err_q;
        // Outputs stay at RUN defaults while reset is held low.
        if (reset) begin
            unique case (state_q)
                RUN: begin
                    if (BranchTaken_EX) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (lu) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end else if (MulDiv_ID) begin
                        MulDiv_start = 1'b1;
                        wcnt_d       = '0;
                        state_d      = MULDIV_WAIT;
                    end
                end
                MULDIV_WAIT: begin
                    if (MulDiv_done) begin
                        state_d = RUN;
                    end else if (wcnt_q == TMO) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        wcnt_d      = wcnt_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign MulDiv_err = err_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .inc     (!PCWrite),
        .clr     (Counter_clr),
        .count_o (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table plus multi-cycle sequences.
// Expected controls go through a scoreboard queue; a small model tracks stall_cycles.
module tb_hazard_control_unit;

    localparam int CNT_W = 5;
    localparam int TMO   = 32;

    typedef struct {
        logic       memrd;
        logic [4:0] rt_ex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrt;
        logic       muldiv;
        logic       done;
        logic       br;
        logic       clr;
        logic [4:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             MemRead_EX = 1'b0;
    logic [4:0]       rt_EX = '0;
    logic [4:0]       rs_ID = '0;
    logic [4:0]       rt_ID = '0;
    logic             UsesRt_ID = 1'b0;
    logic             MulDiv_ID = 1'b0;
    logic             MulDiv_done = 1'b0;
    logic             BranchTaken_EX = 1'b0;
    logic             Counter_clr = 1'b0;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic             MulDiv_start, MulDiv_err;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic exp_err = 1'b0;
    logic [4:0] exp_q[$];

    // Expected control patterns {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDiv_start}
    localparam logic [4:0] O_DEF = 5'b11000;
    localparam logic [4:0] O_STL = 5'b00010;
    localparam logic [4:0] O_BR  = 5'b11110;
    localparam logic [4:0] O_ST  = 5'b11001;

    hazard_control_unit #(
        .MULDIV_TIMEOUT (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead_EX     (MemRead_EX),
        .rt_EX          (rt_EX),
        .rs_ID          (rs_ID),
        .rt_ID          (rt_ID),
        .UsesRt_ID      (UsesRt_ID),
        .MulDiv_ID      (MulDiv_ID),
        .MulDiv_done    (MulDiv_done),
        .BranchTaken_EX (BranchTaken_EX),
        .Counter_clr    (Counter_clr),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .MulDiv_start   (MulDiv_start),
        .MulDiv_err     (MulDiv_err),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic memrd, logic [4:0] rt_ex, logic [4:0] rs,
                                logic [4:0] rt, logic usesrt, logic muldiv,
                                logic done, logic br, logic clr, logic [4:0] exp);
        vec_t v;
        v.memrd = memrd; v.rt_ex = rt_ex; v.rs = rs; v.rt = rt;
        v.usesrt = usesrt; v.muldiv = muldiv; v.done = done;
        v.br = br; v.clr = clr; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ctl_chk(input string nm, input logic [4:0] exp);
        chk({nm, ".PCWrite"}, int'(PCWrite), int'(exp[4]));
        chk({nm, ".IF_ID_Write"}, int'(IF_ID_Write), int'(exp[3]));
        chk({nm, ".IF_ID_Flush"}, int'(IF_ID_Flush), int'(exp[2]));
        chk({nm, ".ID_EX_Flush"}, int'(ID_EX_Flush), int'(exp[1]));
        chk({nm, ".MulDiv_start"}, int'(MulDiv_start), int'(exp[0]));
    endtask

    task automatic drive(input vec_t v);
        MemRead_EX = v.memrd; rt_EX = v.rt_ex; rs_ID = v.rs; rt_ID = v.rt;
        UsesRt_ID = v.usesrt; MulDiv_ID = v.muldiv; MulDiv_done = v.done;
        BranchTaken_EX = v.br; Counter_clr = v.clr;
    endtask

    // Drive one cycle, compare at the falling edge, then advance the stall-count model.
    task automatic apply(input vec_t v, input string nm);
        logic [4:0] e;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        ctl_chk(nm, e);
        chk({nm, ".stall_cycles"}, int'(stall_cycles), exp_cnt);
        chk({nm, ".MulDiv_err"}, int'(MulDiv_err), int'(exp_err));
        if (v.clr) exp_cnt = 0;
        else if (!e[4] && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];
    vec_t idle, stall_v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
        tbl[1] = mk(1, 5, 5, 0, 0, 0, 0, 0, 0, O_STL);
        tbl[2] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, O_DEF);
        tbl[3] = mk(1, 5, 6, 5, 0, 0, 0, 0, 0, O_DEF);
        tbl[4] = mk(1, 5, 6, 5, 1, 0, 0, 0, 0, O_STL);
        tbl[5] = mk(0, 5, 5, 5, 1, 0, 0, 0, 0, O_DEF);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR);
        tbl[7] = mk(1, 5, 5, 0, 0, 1, 0, 1, 0, O_BR);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_DEF);
        tbl[9] = mk(1, 7, 1, 7, 1, 0, 0, 1, 0, O_BR);
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
        stall_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_STL);

        // Reset held with a load-use pattern present: outputs must stay at defaults.
        drive(tbl[1]);
        #3;
        ctl_chk("reset_defaults", O_DEF);
        chk("reset.stall_cycles", int'(stall_cycles), 0);
        chk("reset.MulDiv_err", int'(MulDiv_err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_DEF), "lu_clr");
        apply(tbl[1], "lu_stall");
        apply(idle, "lu_after");
        chk("lu_count", int'(stall_cycles), 1);

        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_DEF), "md_clr");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_ST), "md_start");
        apply(stall_v, "md_w1");
        apply(mk(1, 5, 5, 0, 0, 0, 0, 1, 0, O_STL), "md_w2_br");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_STL), "md_w3_mdid");
        apply(stall_v, "md_w4");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_DEF), "md_done");
        apply(idle, "md_after");
        chk("md_count", int'(stall_cycles), 4);

        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_DEF), "to_clr");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_ST), "to_start");
        for (int k = 0; k < TMO; k++) apply(stall_v, $sformatf("to_w%0d", k));
        apply(idle, "to_release");
        exp_err = 1'b1;
        apply(idle, "to_run");
        chk("to_sat_count", int'(stall_cycles), (1 << CNT_W) - 1);
        apply(tbl[1], "to_lu_after");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_ST), "to_md2");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_DEF), "to_md2_done");
        apply(idle, "to_err_sticky");

        // Asynchronous reset in the middle of a mult/div wait.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_DEF), "rs_clr");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_ST), "rs_start");
        apply(stall_v, "rs_w1");
        drive(stall_v);
        @(negedge clk);
        ctl_chk("rs_pre", O_STL);
        chk("rs_pre.stall_cycles", int'(stall_cycles), 1);
        #1;
        reset = 1'b0;
        drive(tbl[1]);
        #1;
        ctl_chk("rs_async", O_DEF);
        chk("rs_async.stall_cycles", int'(stall_cycles), 0);
        chk("rs_async.MulDiv_err", int'(MulDiv_err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
        apply(idle, "rs_run1");
        apply(idle, "rs_run2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
